// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux into a single registered output stage; select by sel port or round-robin (MUX_RR_EN).
// Latency: 1 cycle from input transfer to out_valid; sustains 1 word/cycle with out_ready held high.
// Backpressure: in_ready of the granted channel follows (!out_valid || out_ready) combinationally; all other in_ready are 0.
//
// Build option: define MUX_RR_EN to enable the round-robin pointer, RR grant logic and the mode input.
// Without it the block is fixed-select only and mode is ignored.

module stream_mux_rr #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [$clog2(N)-1:0] sel,
    input  logic                 mode,
    output logic [W-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_ch
);

    localparam int SW = $clog2(N);

    // Per-channel view of the flat input bus.
    logic [W-1:0] ch_data [N];

    for (genvar k = 0; k < N; k++) begin : g_ch
        assign ch_data[k] = in_data[k*W +: W];
    end

    // Output stage can accept a word when empty or draining; never during reset.
    logic load_en;
    assign load_en = !rst && (!out_valid || out_ready);

    // Fixed-select grant: an out-of-range sel (non-power-of-two N) grants nobody.
    logic fix_vld;
    assign fix_vld = ({1'b0, sel} < (SW+1)'(N));

    logic [SW-1:0] gnt_g;
    logic          gnt_vld;
    logic          xfer;

`ifdef MUX_RR_EN
    logic [SW-1:0] ptr;
    logic [SW-1:0] rr_g;
    logic          rr_vld;
    logic [SW:0]   rr_idx;

    // Round-robin search: first valid channel at or after ptr, wrapping modulo N.
    always_comb begin
        rr_vld = 1'b0;
        rr_g   = '0;
        rr_idx = '0;
        for (int k = 0; k < N; k++) begin
            rr_idx = {1'b0, ptr} + (SW+1)'(k);
            if (rr_idx >= (SW+1)'(N)) begin
                rr_idx = rr_idx - (SW+1)'(N);
            end
            if (!rr_vld && in_valid[rr_idx[SW-1:0]]) begin
                rr_vld = 1'b1;
                rr_g   = rr_idx[SW-1:0];
            end
        end
    end

    assign gnt_g   = mode ? rr_g   : sel;
    assign gnt_vld = mode ? rr_vld : fix_vld;

    // Pointer advances past the served channel only on an RR transfer; the wrap is explicit for non-power-of-two N.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer && mode) begin
            ptr <= (rr_g == SW'(N-1)) ? '0 : rr_g + SW'(1);
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    assign gnt_g   = sel;
    assign gnt_vld = fix_vld;
`endif

    assign xfer = gnt_vld && load_en && in_valid[gnt_g];

    // Only the granted channel sees ready, and only when the output stage can take a word.
    always_comb begin
        in_ready = '0;
        if (gnt_vld && load_en) begin
            in_ready = N'(1) << gnt_g;
        end
    end

    // Single-entry output register: load on transfer, empty when draining with nothing to load, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= ch_data[gnt_g];
                out_ch   <= gnt_g;
            end
        end
    end

endmodule
